// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory boot loader: FSM state encoding and
// the instruction word size that a complete image must be a multiple of.
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  localparam int INSTR_BYTES = 4;
  localparam int INSTR_LSB   = $clog2(INSTR_BYTES);

  // True when a byte count lands on an instruction-word boundary.
  function automatic logic word_aligned(input logic [INSTR_LSB-1:0] low_bits);
    return low_bits == '0;
  endfunction

endpackage

// File: rtl/loader_write_stage.sv
// Registered byte-write port into instruction memory, with the running byte
// count (which doubles as the write address) and modulo-256 checksum.
module loader_write_stage #(
  parameter int noal = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            mem_we,
  output logic [noal-1:0] mem_waddr,
  output logic [7:0]      mem_wdata,
  output logic [noal:0]   byte_count,
  output logic [7:0]      checksum,
  output logic            full
);

  localparam logic [noal:0] CNT_ONE = {{noal{1'b0}}, 1'b1};

  logic            mem_we_q, mem_we_d;
  logic [noal-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic [noal:0]   count_q, count_d;
  logic [7:0]      sum_q, sum_d;

  // The next write address is the number of bytes already written, so the
  // address can never wrap: once count reaches 2**noal the top level stops
  // issuing writes.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    sum_d       = sum_q;
    if (clear) begin
      count_d = '0;
      sum_d   = '0;
    end else if (wr_en) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = count_q[noal-1:0];
      mem_wdata_d = wr_data;
      count_d     = count_q + CNT_ONE;
      sum_d       = sum_q + wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      sum_q       <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign byte_count = count_q;
  assign checksum   = sum_q;
  assign full       = count_q[noal];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory while holding the core in
// reset, then releases it once a whole number of instruction words has landed.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int noal = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            mem_we,
  output logic [noal-1:0] mem_waddr,
  output logic [7:0]      mem_wdata,
  output logic            core_rst_n,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [noal:0]   byte_count,
  output logic [7:0]      checksum
);

  // Handshake: a byte transfers on every rising edge where in_valid and
  // in_ready are both high. in_ready is a flop decoded from the next state
  // only (high exactly while in LOAD) and never looks at in_valid.

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   error_q, error_d;
  logic   core_rst_n_q, core_rst_n_d;

  logic                 accept;
  logic                 clear;
  logic                 wr_en;
  logic                 full;
  logic [INSTR_LSB-1:0] cnt_low_next;

  assign accept       = in_valid & in_ready_q;
  assign cnt_low_next = byte_count[INSTR_LSB-1:0] + INSTR_LSB'(1);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (full) begin
            state_d = ST_ERROR;
          end else begin
            wr_en = 1'b1;
            // The count after this byte is at least 1, so alignment alone
            // decides whether the image is complete.
            if (in_last) begin
              state_d = word_aligned(cnt_low_next) ? ST_RELEASE : ST_ERROR;
            end
          end
        end
      end
      ST_RELEASE: state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase

    in_ready_d   = (state_d == ST_LOAD);
    busy_d       = (state_d == ST_LOAD);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    core_rst_n_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  loader_write_stage #(
    .noal(noal)
  ) u_write_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_data    (in_data),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .byte_count (byte_count),
    .checksum   (checksum),
    .full       (full)
  );

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed plus randomized bench for imem_boot_loader with a small address
// space so the overflow path is reachable.
module tb_imem_boot_loader;

  localparam int NOAL  = 4;
  localparam int CAP   = 1 << NOAL;
  localparam int INSTR = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_REL  = 2;
  localparam int PH_DONE = 3;
  localparam int PH_ERR  = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_last;
  logic            in_ready;
  logic            mem_we;
  logic [NOAL-1:0] mem_waddr;
  logic [7:0]      mem_wdata;
  logic            core_rst_n;
  logic            busy;
  logic            done;
  logic            error;
  logic [NOAL:0]   byte_count;
  logic [7:0]      checksum;

  imem_boot_loader #(.noal(NOAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  int ph;
  int cnt;
  int sum;
  int errors;
  int checks;
  logic [NOAL+7:0] exp_q[$];
  logic [7:0]      img_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    chk("in_ready",   32'(in_ready),   32'(ph == PH_LOAD));
    chk("busy",       32'(busy),       32'(ph == PH_LOAD));
    chk("done",       32'(done),       32'(ph == PH_DONE));
    chk("error",      32'(error),      32'(ph == PH_ERR));
    chk("core_rst_n", 32'(core_rst_n), 32'(ph == PH_DONE));
    chk("byte_count", 32'(byte_count), 32'(cnt));
    chk("checksum",   32'(checksum),   32'(sum));
  endtask

  // One clock of stimulus; inputs change on the falling edge, outputs are
  // checked on the next falling edge against the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic last, input logic st);
    logic exp_we;
    logic [NOAL+7:0] w;
    in_valid = v;
    in_data  = d;
    in_last  = last;
    start    = st;
    exp_we   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    case (ph)
      PH_IDLE, PH_DONE, PH_ERR: begin
        if (st) begin
          ph  = PH_LOAD;
          cnt = 0;
          sum = 0;
        end
      end
      PH_REL: ph = PH_DONE;
      PH_LOAD: begin
        if (v) begin
          if (cnt == CAP) begin
            ph = PH_ERR;
          end else begin
            exp_we = 1'b1;
            exp_q.push_back({NOAL'(cnt), d});
            cnt = cnt + 1;
            sum = (sum + int'(d)) % 256;
            if (last) ph = (cnt % INSTR == 0) ? PH_REL : PH_ERR;
          end
        end
      end
      default: ph = PH_IDLE;
    endcase
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    if (mem_we === 1'b1 && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("mem_waddr", 32'(mem_waddr), 32'(w[NOAL+7:8]));
      chk("mem_wdata", 32'(mem_wdata), 32'(w[7:0]));
    end
    check_status();
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  // driver: send img_q with random idle gaps between bytes
  task automatic send_img(input int gmin, input int gmax, input logic with_last);
    for (int i = 0; i < img_q.size(); i++) begin
      int g;
      g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      repeat (g) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
      cycle(1'b1, img_q[i], with_last && (i == img_q.size() - 1), 1'b0);
    end
  endtask

  task automatic rand_img(input int len);
    img_q.delete();
    for (int i = 0; i < len; i++) img_q.push_back(8'($urandom));
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    ph  = PH_IDLE;
    cnt = 0;
    sum = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    ph       = PH_IDLE;
    cnt      = 0;
    sum      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check_status();
    chk("reset_mem_we",    32'(mem_we),    32'd0);
    chk("reset_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    // idle ignores stream bytes; core stays held
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // normal load
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    img_q = '{8'h63, 8'h00, 8'h00, 8'h00, 8'h33, 8'h81, 8'h00, 8'h00};
    send_img(0, 0, 1'b1);
    chk("normal_count", 32'(byte_count), 32'd8);
    chk("normal_sum",   32'(checksum),   32'h17);
    chk("release_core", 32'(core_rst_n), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("done_core",    32'(core_rst_n), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // reload from DONE with gapped stream; start during LOAD is ignored
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reload_core", 32'(core_rst_n), 32'd0);
    rand_img(4);
    send_img(2, 2, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // partial word
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    rand_img(5);
    send_img(0, 1, 1'b1);
    chk("partial_error", 32'(error),      32'd1);
    chk("partial_count", 32'(byte_count), 32'd5);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("retry_busy",  32'(busy),       32'd1);
    chk("retry_count", 32'(byte_count), 32'd0);

    // overflow: 17 bytes, no last
    rand_img(CAP + 1);
    send_img(0, 0, 1'b0);
    chk("ovf_error", 32'(error),      32'd1);
    chk("ovf_count", 32'(byte_count), 32'(CAP));
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // reset mid-load after 3 bytes
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    rand_img(3);
    send_img(0, 0, 1'b0);
    mid_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // randomized images
    for (int n = 0; n < 12; n++) begin
      int len;
      len = int'($urandom_range(CAP + 1, 1));
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      rand_img(len);
      send_img(0, 2, (len <= CAP) ? 1'b1 : 1'($urandom_range(1, 0)));
      repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences programming of the byte-wide, little-endian instruction memory from an 8-bit valid/ready byte stream.
- Holds the pipeline in reset while loading and releases it, with PC restarting at 0, once a complete image has been written.
- Sits between the external/debug boot source and the instruction memory write port. The core fetch path (read_address/instruction_out) is untouched.

Parameters:
- noal, 8, number of instruction-memory address lines; capacity is 2**noal bytes.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse to begin a load; ignored unless in IDLE or DONE or ERROR
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data, lowest address first
- in_last  input  1  marks the final byte of the image; qualified by in_valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction-memory byte write enable
- mem_waddr  output  noal  byte write address
- mem_wdata  output  8  byte write data
- core_rst_n  output  1  active-low reset to the pipeline (PC, pipeline registers)
- busy  output  1  high in LOAD
- done  output  1  high in DONE
- error  output  1  high in ERROR
- byte_count  output  noal+1  bytes written in current or last load
- checksum  output  8  modulo-256 sum of bytes written in current or last load

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0.
  - core_rst_n=0, busy=0, done=0, error=0, byte_count=0, checksum=0.
- States: IDLE, LOAD, RELEASE, DONE, ERROR.
- IDLE:
  - core_rst_n=0, so the core is never released without a valid image.
  - start -> LOAD; byte_count, checksum and the address counter are cleared on the same edge.
- LOAD:
  - in_ready=1, busy=1, core_rst_n=0.
  - A byte is accepted on any edge where in_valid & in_ready.
- Write timing:
  - An accepted byte is registered onto mem_we=1, mem_waddr=addr, mem_wdata=in_data in the next cycle. Write latency is exactly 1 cycle.
  - addr increments by 1 per accepted byte.
  - mem_we is 0 in every cycle with no accepted byte in the previous cycle.
- Counters:
  - byte_count and checksum update on the same edge the write is issued.
  - checksum = (checksum + byte) mod 256.
- Capacity overflow: a byte accepted when byte_count == 2**noal (address space full) is not written. -> ERROR.
  - The address counter therefore never wraps. byte_count is noal+1 bits so that full capacity is representable.
- Accepted byte with in_last=1:
  - Resulting total byte count a multiple of 4 and nonzero -> RELEASE.
  - Otherwise -> ERROR (partial instruction word).
- start while in LOAD is ignored.
- RELEASE:
  - One cycle; in_ready=0, core_rst_n still 0.
  - This lets the final write land before the core fetches from address 0. -> DONE.
- DONE:
  - core_rst_n=1, done=1; byte_count and checksum are held.
  - start -> LOAD; core_rst_n drops to 0 on that edge (reload re-holds the core).
- ERROR:
  - error=1, core_rst_n=0, in_ready=0; counters are held for diagnosis.
  - start -> LOAD (retry); only rst_n or start exits.
- in_ready is a registered function of state only (high exactly in LOAD) and does not depend on in_valid.
- rst_n asserted mid-load: immediate return to IDLE, core held, partial image is abandoned. Memory contents are not cleared.
- The same-edge in_valid with in_last and start are independent; start has no effect in LOAD.

Decomposition:
- Shared package imem_pkg: state enum (IDLE, LOAD, RELEASE, DONE, ERROR) and the localparam INSTR_BYTES=4.
- One sub-module, loader_write_stage: the registered byte-write port plus address/count/checksum counters.
- The top level holds the FSM and handshake.

Test Plan:
- Normal load:
  - start, then 8 bytes 63,00,00,00,33,81,00,00 with in_last on the 8th.
  - Required: mem writes to addresses 0..7 one cycle after each accept; byte_count=8; checksum=0x17.
  - RELEASE for 1 cycle, then done=1 and core_rst_n=1.
- Backpressure/gaps: in_valid toggled 1,0,0,1,... over a 4-byte image.
  - Required: mem_we only in cycles following accepts; addresses contiguous 0..3.
- Partial word: 5 bytes with in_last on byte 5.
  - Required: error=1, byte_count=5, core_rst_n=0.
  - A subsequent start gives busy=1 and byte_count=0.
- Overflow (noal=4): 17 bytes with no in_last.
  - Required: 16 writes to addresses 0..15, 17th byte not written, error=1, byte_count=16.
- Reset mid-load: rst_n pulsed low after 3 bytes.
  - Required: asynchronous IDLE, mem_we=0 immediately, core_rst_n=0, byte_count=0.
- Reload from DONE: start pulse.
  - Required: core_rst_n falls on that edge; the second image overwrites from address 0.
